// File: rtl/tdm_slot_dispatch.sv
// TDM slot demux and per-channel word packer with a serial return-path mux.
// Define TDM_PROTO_CHECK_EN to enable per-channel sop/eop protocol checking and err_cnt.
module tdm_slot_dispatch #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PORTS  = 10,
    parameter int WORD_BEATS = 4,
    localparam int SLOT_W    = $clog2(NUM_PORTS),
    localparam int CNT_W     = $clog2(WORD_BEATS + 1)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    input  logic                                       in_sop,
    input  logic                                       in_eop,
    input  logic [DATA_WIDTH-1:0]                      in_data,
    output logic [SLOT_W-1:0]                          slot,
    output logic                                       frame_start,
    output logic [NUM_PORTS-1:0]                       ch_wr,
    output logic [NUM_PORTS-1:0]                       ch_sop,
    output logic [NUM_PORTS-1:0]                       ch_eop,
    output logic [NUM_PORTS*CNT_W-1:0]                 ch_bcnt,
    output logic [NUM_PORTS*WORD_BEATS*DATA_WIDTH-1:0] ch_data,
    input  logic [NUM_PORTS-1:0]                       ret_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]            ret_data,
    output logic                                       out_valid,
    output logic [DATA_WIDTH-1:0]                      out_data,
    output logic [15:0]                                err_cnt
);

    localparam int WORD_W = WORD_BEATS * DATA_WIDTH;

    logic [CNT_W-1:0]  bc_q       [NUM_PORTS];
    logic [WORD_W-1:0] buf_q      [NUM_PORTS];
    logic              sop_seen_q [NUM_PORTS];
    logic [CNT_W-1:0]  bcnt_q     [NUM_PORTS];
    logic [WORD_W-1:0] data_q     [NUM_PORTS];

    logic [CNT_W-1:0]  lane;
    logic [CNT_W-1:0]  cnt_d;
    logic [WORD_W-1:0] word_d;
    logic              sop_d;
    logic              beat_take;
    logic              word_done;

    assign frame_start = (slot == '0);

`ifdef TDM_PROTO_CHECK_EN
    typedef enum logic {ST_IDLE, ST_PKT} pkt_state_e;

    pkt_state_e state_q [NUM_PORTS];
    pkt_state_e state_d [NUM_PORTS];
    logic       err_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= ST_IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // A lone sop+eop beat is a whole packet, so the channel never leaves IDLE for it.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            state_d[i] = state_q[i];
        end
        if (in_valid) begin
            case (state_q[slot])
                ST_IDLE: if (in_sop && !in_eop) state_d[slot] = ST_PKT;
                ST_PKT:  if (in_eop) state_d[slot] = ST_IDLE;
                default: state_d[slot] = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        beat_take = 1'b0;
        err_inc   = 1'b0;
        if (in_valid) begin
            case (state_q[slot])
                ST_IDLE: begin
                    beat_take = in_sop;
                    err_inc   = !in_sop;
                end
                ST_PKT: begin
                    beat_take = 1'b1;
                    err_inc   = in_sop;
                end
                default: begin
                    beat_take = 1'b0;
                    err_inc   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_inc && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`else
    assign beat_take = in_valid;
    assign err_cnt   = '0;
`endif

    // A sop beat restarts the word at lane 0 on an empty buffer, dropping any partial word.
    always_comb begin
        lane      = in_sop ? '0 : bc_q[slot];
        word_d    = in_sop ? '0 : buf_q[slot];
        word_d[int'(lane)*DATA_WIDTH +: DATA_WIDTH] = in_data;
        cnt_d     = lane + CNT_W'(1);
        sop_d     = in_sop | sop_seen_q[slot];
        word_done = beat_take & (in_eop | (cnt_d == CNT_W'(WORD_BEATS)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot      <= '0;
            ch_wr     <= '0;
            ch_sop    <= '0;
            ch_eop    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                bc_q[i]       <= '0;
                buf_q[i]      <= '0;
                sop_seen_q[i] <= 1'b0;
                bcnt_q[i]     <= '0;
                data_q[i]     <= '0;
            end
        end else begin
            slot      <= (slot == SLOT_W'(NUM_PORTS - 1)) ? '0 : slot + SLOT_W'(1);
            ch_wr     <= '0;
            out_valid <= ret_valid[slot];
            out_data  <= ret_valid[slot] ? ret_data[int'(slot)*DATA_WIDTH +: DATA_WIDTH] : '0;
            if (word_done) begin
                ch_wr[slot]      <= 1'b1;
                ch_sop[slot]     <= sop_d;
                ch_eop[slot]     <= in_eop;
                bcnt_q[slot]     <= cnt_d;
                data_q[slot]     <= word_d;
                bc_q[slot]       <= '0;
                buf_q[slot]      <= '0;
                sop_seen_q[slot] <= 1'b0;
            end else if (beat_take) begin
                bc_q[slot]       <= cnt_d;
                buf_q[slot]      <= word_d;
                sop_seen_q[slot] <= sop_d;
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_flat
        assign ch_bcnt[g*CNT_W +: CNT_W]   = bcnt_q[g];
        assign ch_data[g*WORD_W +: WORD_W] = data_q[g];
    end

endmodule

// File: tb/tb_tdm_slot_dispatch.sv
// Scoreboard bench for tdm_slot_dispatch: a beat-list reference model predicts words,
// slot sequence, return path and err_cnt (honours TDM_PROTO_CHECK_EN).
module tb_tdm_slot_dispatch;

    localparam int DW = 8;
    localparam int NP = 10;
    localparam int WB = 4;
    localparam int CW = 3;
    localparam int SW = 4;
    localparam int WW = WB * DW;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_sop;
    logic                in_eop;
    logic [DW-1:0]       in_data;
    logic [SW-1:0]       slot;
    logic                frame_start;
    logic [NP-1:0]       ch_wr;
    logic [NP-1:0]       ch_sop;
    logic [NP-1:0]       ch_eop;
    logic [NP*CW-1:0]    ch_bcnt;
    logic [NP*WW-1:0]    ch_data;
    logic [NP-1:0]       ret_valid;
    logic [NP*DW-1:0]    ret_data;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic [15:0]         err_cnt;

    tdm_slot_dispatch #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .WORD_BEATS(WB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_data(in_data), .slot(slot), .frame_start(frame_start), .ch_wr(ch_wr),
        .ch_sop(ch_sop), .ch_eop(ch_eop), .ch_bcnt(ch_bcnt), .ch_data(ch_data),
        .ret_valid(ret_valid), .ret_data(ret_data), .out_valid(out_valid),
        .out_data(out_data), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        int            ch;
        logic          sop;
        logic          eop;
        int            bcnt;
        logic [WW-1:0] data;
    } word_exp_t;

    typedef struct {
        int            due;
        logic          is_rst;
        int            slot;
        logic          ov;
        logic [DW-1:0] od;
        logic [15:0]   err;
    } cyc_exp_t;

    word_exp_t word_q[$];
    cyc_exp_t  cyc_q[$];

    int tests = 0;
    int fails = 0;

    int            m_slot;
    int            m_err;
    logic [DW-1:0] part_beats [NP][WB];
    int            part_len   [NP];
    logic          part_sop   [NP];
    logic          in_pkt     [NP];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clearModel();
        m_slot = 0;
        m_err  = 0;
        for (int i = 0; i < NP; i++) begin
            part_len[i] = 0;
            part_sop[i] = 1'b0;
            in_pkt[i]   = 1'b0;
        end
    endtask

    // Beats are collected as a list per channel; a word is released on eop or when the list is full.
    task automatic modelBeat(input int ch, input logic sop, input logic eop, input logic [DW-1:0] d);
        logic [WW-1:0] w;
`ifdef TDM_PROTO_CHECK_EN
        if (!in_pkt[ch] && !sop) begin
            if (m_err < 65535) m_err++;
            return;
        end
        if (in_pkt[ch] && sop && m_err < 65535) m_err++;
        if (sop) in_pkt[ch] = 1'b1;
        if (eop) in_pkt[ch] = 1'b0;
`endif
        if (sop) begin
            part_len[ch] = 0;
            part_sop[ch] = 1'b1;
        end
        part_beats[ch][part_len[ch]] = d;
        part_len[ch]++;
        if (eop || part_len[ch] == WB) begin
            w = '0;
            for (int i = 0; i < part_len[ch]; i++) w[i*DW +: DW] = part_beats[ch][i];
            word_q.push_back('{due: cyc + 1, ch: ch, sop: part_sop[ch], eop: eop,
                               bcnt: part_len[ch], data: w});
            part_len[ch] = 0;
            part_sop[ch] = 1'b0;
        end
    endtask

    task automatic randomizeReturn();
        ret_valid = NP'($urandom);
        ret_data  = (NP*DW)'({$urandom, $urandom, $urandom});
    endtask

    task automatic applyStimulus(input logic v, input logic sop, input logic eop, input logic [DW-1:0] d);
        cyc_exp_t ce;
        rst      = 1'b0;
        in_valid = v;
        in_sop   = sop;
        in_eop   = eop;
        in_data  = d;
        randomizeReturn();
        if (v) modelBeat(m_slot, sop, eop, d);
        ce.due    = cyc + 1;
        ce.is_rst = 1'b0;
        ce.slot   = (m_slot + 1) % NP;
        ce.ov     = ret_valid[m_slot];
        ce.od     = ce.ov ? ret_data[m_slot*DW +: DW] : '0;
        ce.err    = 16'(m_err);
        cyc_q.push_back(ce);
        @(posedge clk);
        #1;
        m_slot = (m_slot + 1) % NP;
    endtask

    task automatic applyReset(input int n);
        for (int i = 0; i < n; i++) begin
            rst      = 1'b1;
            in_valid = 1'b0;
            in_sop   = 1'b0;
            in_eop   = 1'b0;
            in_data  = '0;
            randomizeReturn();
            cyc_q.push_back('{due: cyc + 1, is_rst: 1'b1, slot: 0, ov: 1'b0, od: '0, err: '0});
            @(posedge clk);
            #1;
        end
        clearModel();
    endtask

    task automatic sendBeat(input int ch, input logic sop, input logic eop, input logic [DW-1:0] d);
        while (m_slot != ch) applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, sop, eop, d);
    endtask

    always @(negedge clk) begin
        cyc_exp_t  ce;
        word_exp_t we;
        if (cyc_q.size() > 0 && cyc_q[0].due == cyc) begin
            ce = cyc_q.pop_front();
            checkOutput("slot", 64'(slot), 64'(ce.slot));
            checkOutput("frame_start", 64'(frame_start), 64'(ce.slot == 0));
            checkOutput("out_valid", 64'(out_valid), 64'(ce.ov));
            checkOutput("out_data", 64'(out_data), 64'(ce.od));
            checkOutput("err_cnt", 64'(err_cnt), 64'(ce.err));
            if (ce.is_rst) begin
                checkOutput("rst_ch_wr", 64'(ch_wr), 64'd0);
                checkOutput("rst_ch_sop_eop", 64'({ch_sop, ch_eop}), 64'd0);
                checkOutput("rst_ch_bcnt", 64'(ch_bcnt), 64'd0);
                checkOutput("rst_ch_data_nonzero", 64'(|ch_data), 64'd0);
            end
        end
        while (word_q.size() > 0 && word_q[0].due < cyc) begin
            we = word_q.pop_front();
            tests++;
            fails++;
            $display("[TB] FAIL missed_strobe: ch %0d got no ch_wr expected strobe at cycle %0d", we.ch, we.due);
        end
        if (ch_wr != '0) begin
            if (word_q.size() == 0 || word_q[0].due != cyc) begin
                checkOutput("unexpected_strobe", 64'(ch_wr), 64'd0);
            end else begin
                we = word_q.pop_front();
                checkOutput("ch_wr", 64'(ch_wr), 64'(1) << we.ch);
                checkOutput("ch_sop", 64'(ch_sop[we.ch]), 64'(we.sop));
                checkOutput("ch_eop", 64'(ch_eop[we.ch]), 64'(we.eop));
                checkOutput("ch_bcnt", 64'(ch_bcnt[we.ch*CW +: CW]), 64'(we.bcnt));
                checkOutput("ch_data", 64'(ch_data[we.ch*WW +: WW]), 64'(we.data));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        in_data   = '0;
        ret_valid = '0;
        ret_data  = '0;
        clearModel();
        applyReset(3);

        repeat (20) applyStimulus(1'b0, 1'b0, 1'b0, '0);

        sendBeat(3, 1'b1, 1'b0, 8'h11);
        sendBeat(3, 1'b0, 1'b0, 8'h12);
        sendBeat(3, 1'b0, 1'b0, 8'h13);
        sendBeat(3, 1'b0, 1'b0, 8'h14);
        sendBeat(3, 1'b0, 1'b0, 8'h15);
        sendBeat(3, 1'b0, 1'b1, 8'h16);

        sendBeat(9, 1'b1, 1'b1, 8'hAB);

        sendBeat(0, 1'b1, 1'b0, 8'h21);
        sendBeat(0, 1'b0, 1'b0, 8'h22);
        applyReset(1);
        sendBeat(0, 1'b1, 1'b0, 8'h31);
        sendBeat(0, 1'b0, 1'b0, 8'h32);
        sendBeat(0, 1'b0, 1'b0, 8'h33);
        sendBeat(0, 1'b0, 1'b1, 8'h34);

        sendBeat(2, 1'b0, 1'b0, 8'h41);
        sendBeat(2, 1'b1, 1'b0, 8'h42);
        sendBeat(2, 1'b0, 1'b0, 8'h43);
        sendBeat(2, 1'b1, 1'b0, 8'h44);
        sendBeat(2, 1'b0, 1'b1, 8'h45);

        for (int n = 0; n < 900; n++) begin
            if (n == 450) applyReset(2);
            applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 30,
                          $urandom_range(0, 99) < 30, DW'($urandom));
        end

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        #1;
        checkOutput("leftover_words", 64'(word_q.size()), 64'd0);
        checkOutput("leftover_cycles", 64'(cyc_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
